gate_vector_checker: RTL and testbench



---
 rtl/gate_check_pkg.sv | 21 ++
 rtl/gate_vector_checker_if.sv | 31 +++
 rtl/gate_settle_timer.sv | 29 ++
 rtl/gate_vector_checker.sv | 130 +++++++++++++
 tb/tb_gate_vector_checker.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_check_pkg.sv
// Shared definitions for the two-input gate checker.
//   state_t     : sweep controller states
//   TT_*        : expected truth tables for N_IN=2 (bit v = y for input vector v)
package gate_check_pkg;

    // S_ prefix keeps the state names clear of the SETTLE parameter.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_vector_checker_if.sv
// Bundle between the checker and the gate-under-test / controlling logic.
//   start    : sweep request (into checker)
//   gate_in  : vector driven to the GUT (bit0 = a, bit1 = b)
//   gate_out : GUT output y (into checker)
//   busy/done/pass/captured/mismatch : sweep status and results (from checker)
// master = checker side, slave = GUT / controller side.
interface gate_vector_checker_if #(
    parameter int N_IN = 2
);
    localparam int NV = 2 ** N_IN;

    logic            start;
    logic [N_IN-1:0] gate_in;
    logic            gate_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [NV-1:0]   captured;
    logic [NV-1:0]   mismatch;

    modport master (
        input  start, gate_out,
        output gate_in, busy, done, pass, captured, mismatch
    );

    modport slave (
        output start, gate_out,
        input  gate_in, busy, done, pass, captured, mismatch
    );

endinterface

// File: rtl/gate_settle_timer.sv
// 8-bit loadable down-counter used to time the settle interval.
//   clk, rst     : clock, synchronous active-high reset
//   i_load       : load i_load_val (has priority over decrement)
//   i_load_val   : value to load
//   i_dec        : decrement while non-zero (saturates at 0)
//   o_zero       : counter is zero
module gate_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && r_cnt != 8'd0)
            r_cnt <= r_cnt - 8'd1;
    end

    assign o_zero = (r_cnt == 8'd0);

endmodule

// File: rtl/gate_vector_checker.sv
// Sweeps every input vector of a gate-under-test in ascending order, holds
// each for SETTLE cycles, samples the output on the following cycle and
// compares it against the EXPECTED truth table.
//   clk, rst : clock, synchronous active-high reset
//   bus      : gate_vector_checker_if.master (start, gate_in, gate_out,
//              busy, done, pass, captured, mismatch)
module gate_vector_checker
    import gate_check_pkg::*;
#(
    parameter int N_IN     = 2,
    parameter int SETTLE   = 4,
    parameter     EXPECTED = TT_AND
) (
    input  logic                  clk,
    input  logic                  rst,
    gate_vector_checker_if.master bus
);

    localparam int            NV   = 2 ** N_IN;
    localparam logic [NV-1:0] EXP  = EXPECTED;
    localparam logic [7:0]    LOAD = 8'(SETTLE - 1);

    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
        $error("gate_vector_checker: SETTLE must be in 1..255");
    end
    if ($bits(EXPECTED) != NV) begin : g_bad_expected
        $error("gate_vector_checker: EXPECTED width must be 2**N_IN");
    end

    state_t          r_state, w_next;
    logic [N_IN-1:0] r_v;
    logic            r_busy, r_done, r_pass;
    logic [NV-1:0]   r_cap, r_mis;
    logic            w_load, w_dec, w_zero, w_last, w_new_mis;
    logic [NV-1:0]   w_mis_final;

    assign w_last      = (r_v == N_IN'(NV - 1));
    assign w_new_mis   = bus.gate_out ^ EXP[r_v];
    // Mismatch vector including the bit being sampled this cycle.
    assign w_mis_final = r_mis | (NV'(w_new_mis) << r_v);

    gate_settle_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (LOAD),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_dec  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_SETTLE;
                    w_load = 1'b1;
                end
            end
            S_SETTLE: begin
                w_dec = 1'b1;
                if (w_zero) w_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_SETTLE;
                    w_load = 1'b1;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v    <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_cap  <= '0;
            r_mis  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_v    <= '0;
                        r_cap  <= '0;
                        r_mis  <= '0;
                        r_pass <= 1'b0;
                        r_busy <= 1'b1;
                    end
                end
                S_SAMPLE: begin
                    r_cap[r_v] <= bus.gate_out;
                    r_mis[r_v] <= w_new_mis;
                    if (!w_last) begin
                        r_v <= r_v + 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (w_mis_final == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    // The vector index is the applied vector; the last one is kept after DONE.
    assign bus.gate_in  = r_v;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.pass     = r_pass;
    assign bus.captured = r_cap;
    assign bus.mismatch = r_mis;

endmodule

// File: tb/tb_gate_vector_checker.sv
module tb_gate_vector_checker;
    import gate_check_pkg::*;

    logic clk = 1'b0;
    logic rst0, rst1;
    always #5 clk = ~clk;

    gate_vector_checker_if #(.N_IN(2)) bus0 ();
    gate_vector_checker_if #(.N_IN(2)) bus1 ();

    gate_vector_checker #(.N_IN(2), .SETTLE(4), .EXPECTED(TT_AND)) dut0 (
        .clk(clk), .rst(rst0), .bus(bus0.master));
    gate_vector_checker #(.N_IN(2), .SETTLE(1), .EXPECTED(TT_XOR)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1.master));

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // GUT selection: 0=AND 1=OR 2=tied-0 3=XOR
    int   sel [2];
    logic noise [2];
    int   S [2]           = '{4, 1};
    logic [3:0] EXPV [2]  = '{TT_AND, TT_XOR};

    function automatic logic gut(int s, logic [1:0] gi);
        logic [3:0] tt;
        case (s)
            0:       tt = TT_AND;
            1:       tt = TT_OR;
            2:       tt = 4'b0000;
            default: tt = TT_XOR;
        endcase
        return tt[gi];
    endfunction

    // GUT plus garbage on its output whenever the checker is not about to sample.
    assign bus0.gate_out = gut(sel[0], bus0.gate_in) ^ noise[0];
    assign bus1.gate_out = gut(sel[1], bus1.gate_in) ^ noise[1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a sweep is a count of cycles since the start edge;
    // every (S+1)-th cycle samples vector k/(S+1)-1.
    bit         m_act  [2];
    int         m_k    [2];
    logic [1:0] m_gi   [2];
    logic [3:0] m_cap  [2];
    logic [3:0] m_mask [2];
    logic       m_done [2];
    logic       m_pass [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0; m_k[d] = 0; m_gi[d] = 0; m_cap[d] = 0;
            m_mask[d] = 0; m_done[d] = 0; m_pass[d] = 0;
            sel[d] = 0; noise[d] = 0;
        end
    end

    task automatic model_step(input int d, input logic r, input logic st);
        int idx;
        if (r) begin
            m_act[d] = 0; m_k[d] = 0; m_gi[d] = 0; m_cap[d] = 0;
            m_mask[d] = 0; m_done[d] = 0; m_pass[d] = 0;
        end else if (m_done[d]) begin
            m_done[d] = 0;
        end else if (m_act[d]) begin
            m_k[d]++;
            if (m_k[d] % (S[d] + 1) == 0) begin
                idx = m_k[d] / (S[d] + 1) - 1;
                m_cap[d][idx]  = gut(sel[d], m_gi[d]);
                m_mask[d][idx] = 1'b1;
                if (idx == 3) begin
                    m_act[d]  = 0;
                    m_done[d] = 1;
                    m_pass[d] = (((m_cap[d] ^ EXPV[d]) & m_mask[d]) == 4'b0);
                end else begin
                    m_gi[d] = 2'(idx + 1);
                end
            end
        end else if (st) begin
            m_act[d] = 1; m_k[d] = 0; m_gi[d] = 0; m_cap[d] = 0;
            m_mask[d] = 0; m_pass[d] = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst0, bus0.start);
        model_step(1, rst1, bus1.start);
    end

    // Noise only where the next edge is not a sample edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++)
            noise[d] = ($urandom_range(0, 1) == 1) &&
                       !(m_act[d] && ((m_k[d] + 1) % (S[d] + 1) == 0));
    end

    task automatic cmp(input int d, input logic [1:0] gi, input logic b, input logic dn,
                       input logic p, input logic [3:0] c, input logic [3:0] m);
        chk($sformatf("d%0d.gate_in", d),  32'(gi), 32'(m_gi[d]));
        chk($sformatf("d%0d.busy", d),     32'(b),  32'(m_act[d]));
        chk($sformatf("d%0d.done", d),     32'(dn), 32'(m_done[d]));
        chk($sformatf("d%0d.pass", d),     32'(p),  32'(m_pass[d]));
        chk($sformatf("d%0d.captured", d), 32'(c),  32'(m_cap[d]));
        chk($sformatf("d%0d.mismatch", d), 32'(m), 32'((m_cap[d] ^ EXPV[d]) & m_mask[d]));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp(0, bus0.gate_in, bus0.busy, bus0.done, bus0.pass, bus0.captured, bus0.mismatch);
            cmp(1, bus1.gate_in, bus1.busy, bus1.done, bus1.pass, bus1.captured, bus1.mismatch);
        end
    end

    // Pulse start on dut0 and return cycles from the start edge until done.
    task automatic sweep0(input int s, output int lat);
        repeat (2) @(negedge clk);
        sel[0] = s;
        bus0.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.start = 1'b0;
        lat = 0;
        while (!bus0.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic res0(input string nm, input logic [3:0] c, input logic [3:0] m, input logic p);
        chk({nm, ".captured"}, 32'(bus0.captured), 32'(c));
        chk({nm, ".mismatch"}, 32'(bus0.mismatch), 32'(m));
        chk({nm, ".pass"},     32'(bus0.pass),     32'(p));
    endtask

    initial begin
        int lat;
        int dn[$];
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.start = 1'b0; bus1.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // reset state
        chk("rst.gate_in", 32'(bus0.gate_in), 0);
        chk("rst.busy",    32'(bus0.busy), 0);
        chk("rst.done",    32'(bus0.done), 0);
        chk("rst.pass",    32'(bus0.pass), 0);
        chk("rst.cap",     32'(bus0.captured), 0);
        chk("rst.mis1",    32'(bus1.mismatch), 0);
        rst0 = 1'b0; rst1 = 1'b0;
        cmp_en = 1'b1;

        // AND cell
        sweep0(0, lat);
        chk("and.latency", 32'(lat), 20);
        res0("and", 4'b1000, 4'b0000, 1'b1);
        // OR cell against AND table
        sweep0(1, lat);
        chk("or.latency", 32'(lat), 20);
        res0("or", 4'b1110, 4'b0110, 1'b0);
        // output tied low
        sweep0(2, lat);
        res0("zero", 4'b0000, 4'b1000, 1'b0);

        // reset mid-sweep while vector 2 settles
        repeat (2) @(negedge clk);
        sel[0] = 0;
        bus0.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst.pre_gi", 32'(bus0.gate_in), 2);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        chk("midrst.gate_in", 32'(bus0.gate_in), 0);
        chk("midrst.busy",    32'(bus0.busy), 0);
        chk("midrst.done",    32'(bus0.done), 0);
        res0("midrst", 4'b0000, 4'b0000, 1'b0);
        sweep0(0, lat);
        chk("fresh.latency", 32'(lat), 20);
        res0("fresh", 4'b1000, 4'b0000, 1'b1);

        // start held high for 50 cycles
        repeat (2) @(negedge clk);
        sel[0] = 0;
        bus0.start = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus0.done) dn.push_back(c);
        end
        bus0.start = 1'b0;
        chk("held.ndone", 32'(dn.size() >= 2), 1);
        if (dn.size() >= 2) begin
            chk("held.done1", 32'(dn[0]), 20);
            chk("held.done2", 32'(dn[1]), 42);
        end
        repeat (30) @(negedge clk);

        // SETTLE=1 XOR instance
        sel[1] = 3;
        bus1.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        lat = 0;
        while (!bus1.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("xor.latency",  32'(lat), 8);
        chk("xor.captured", 32'(bus1.captured), 32'(4'b0110));
        chk("xor.pass",     32'(bus1.pass), 1);

        // random traffic on both instances
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            bus0.start = ($urandom_range(0, 3) == 0);
            bus1.start = ($urandom_range(0, 3) == 0);
            rst0 = ($urandom_range(0, 59) == 0);
            rst1 = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) sel[0] = int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) sel[1] = int'($urandom_range(0, 3));
        end
        @(negedge clk);
        bus0.start = 1'b0; bus1.start = 1'b0;
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (30) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
